// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-port packet arbiter toward the MAC TX stream.
package tx_arb_pkg;
   localparam int NUM_PORTS   = 2;
   localparam int WORD_CNT_W  = 16;
   localparam int GAP_CNT_W   = 16;
   localparam int PKT_CNT_W   = 32;
   localparam int TRUNC_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN,
      GAP
   } arb_state_e;

   // Round-robin pick between two requesters; returns the winning port index.
   function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
      if (v0 && v1) return ~last_grant;
      else if (v1)  return 1'b1;
      else          return 1'b0;
   endfunction
endpackage

// File: rtl/tx_pkt_arbiter_if.sv
// 64-bit AXI-Stream style beat bundle; master drives payload, slave drives tready.
interface tx_pkt_arbiter_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tvalid;
   logic        tlast;
   logic        tuser;
   logic        tready;

   modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                   input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                   output tready);
endinterface

// File: rtl/tx_arb_stats.sv
// Per-port completed-packet counters and truncation counter; all wrap at full scale.
module tx_arb_stats
   import tx_arb_pkg::*;
(
   input  logic                   user_clk,
   input  logic                   reset,
   input  logic                   pkt_done0,
   input  logic                   pkt_done1,
   input  logic                   trunc_evt,
   output logic [PKT_CNT_W-1:0]   pkt_cnt0,
   output logic [PKT_CNT_W-1:0]   pkt_cnt1,
   output logic [TRUNC_CNT_W-1:0] trunc_cnt
);
   logic [PKT_CNT_W-1:0]   pkt_cnt0_q, pkt_cnt0_d;
   logic [PKT_CNT_W-1:0]   pkt_cnt1_q, pkt_cnt1_d;
   logic [TRUNC_CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;

   always_comb begin
      pkt_cnt0_d  = pkt_cnt0_q  + PKT_CNT_W'(pkt_done0);
      pkt_cnt1_d  = pkt_cnt1_q  + PKT_CNT_W'(pkt_done1);
      trunc_cnt_d = trunc_cnt_q + TRUNC_CNT_W'(trunc_evt);
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         pkt_cnt0_q  <= '0;
         pkt_cnt1_q  <= '0;
         trunc_cnt_q <= '0;
      end else begin
         pkt_cnt0_q  <= pkt_cnt0_d;
         pkt_cnt1_q  <= pkt_cnt1_d;
         trunc_cnt_q <= trunc_cnt_d;
      end
   end

   assign pkt_cnt0  = pkt_cnt0_q;
   assign pkt_cnt1  = pkt_cnt1_q;
   assign trunc_cnt = trunc_cnt_q;
endmodule

// File: rtl/tx_pkt_arbiter.sv
// Two-port packet-granular round-robin arbiter with truncation and inter-packet gap.
// Optional statistics counters are built only when TX_ARB_STATS_EN is defined.
module tx_pkt_arbiter
   import tx_arb_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter int MAX_WORDS  = 1024
)(
   input  logic                   user_clk,
   input  logic                   reset,
   tx_pkt_arbiter_if.slave        s0,
   tx_pkt_arbiter_if.slave        s1,
   tx_pkt_arbiter_if.master       m,
   output logic [PKT_CNT_W-1:0]   pkt_cnt0,
   output logic [PKT_CNT_W-1:0]   pkt_cnt1,
   output logic [TRUNC_CNT_W-1:0] trunc_cnt
);
   localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(MAX_WORDS - 1);
   localparam logic [GAP_CNT_W-1:0]  GAP_LOAD  =
      (GAP_CYCLES > 0) ? GAP_CNT_W'(GAP_CYCLES - 1) : '0;

   arb_state_e            state_q, state_d;
   logic                  gnt_vld_q, gnt_vld_d;
   logic                  gnt_idx_q, gnt_idx_d;
   logic                  last_grant_q, last_grant_d;
   logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [GAP_CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

   logic        sel_tvalid, sel_tlast;
   logic [63:0] sel_tdata;
   logic [7:0]  sel_tkeep;
   logic        sel_tready;
   logic        trunc_beat, xfer_acc, pkt_end, rr_idx;
   logic [63:0] m_tdata_o;
   logic [7:0]  m_tkeep_o;
   logic        m_tvalid_o, m_tlast_o, m_tuser_o;

   assign sel_tvalid = gnt_idx_q ? s1.tvalid : s0.tvalid;
   assign sel_tlast  = gnt_idx_q ? s1.tlast  : s0.tlast;
   assign sel_tdata  = gnt_idx_q ? s1.tdata  : s0.tdata;
   assign sel_tkeep  = gnt_idx_q ? s1.tkeep  : s0.tkeep;

   // Output stage; reset blanks the handshake in the same cycle it is seen.
   always_comb begin
      m_tvalid_o = 1'b0;
      m_tdata_o  = '0;
      m_tkeep_o  = '0;
      m_tlast_o  = 1'b0;
      m_tuser_o  = 1'b0;
      sel_tready = 1'b0;
      trunc_beat = 1'b0;
      if (!reset) begin
         case (state_q)
            XFER: begin
               m_tvalid_o = sel_tvalid;
               sel_tready = m.tready;
               trunc_beat = sel_tvalid && (word_cnt_q == LAST_WORD) && !sel_tlast;
               if (sel_tvalid) begin
                  m_tdata_o = sel_tdata;
                  m_tkeep_o = sel_tkeep;
                  m_tlast_o = sel_tlast || trunc_beat;
                  m_tuser_o = trunc_beat;
               end
            end
            DRAIN:   sel_tready = 1'b1;
            default: ;
         endcase
      end
   end

   assign xfer_acc = (state_q == XFER) && sel_tvalid && m.tready;
   assign rr_idx   = rr_pick(s0.tvalid, s1.tvalid, last_grant_q);

   always_comb begin
      state_d      = state_q;
      gnt_vld_d    = gnt_vld_q;
      gnt_idx_d    = gnt_idx_q;
      last_grant_d = last_grant_q;
      word_cnt_d   = word_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      pkt_end      = 1'b0;
      case (state_q)
         IDLE: begin
            if (s0.tvalid || s1.tvalid) begin
               gnt_vld_d    = 1'b1;
               gnt_idx_d    = rr_idx;
               last_grant_d = rr_idx;
               state_d      = XFER;
            end
         end
         XFER: begin
            if (xfer_acc) begin
               word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
               if (sel_tlast) begin
                  pkt_end = 1'b1;
               end else if (trunc_beat) begin
                  state_d    = DRAIN;
                  word_cnt_d = '0;
               end
            end
         end
         DRAIN: begin
            if (sel_tvalid && sel_tlast) pkt_end = 1'b1;
         end
         GAP: begin
            if (gap_cnt_q == '0) state_d = IDLE;
            else                 gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
      // Releasing the grant is common to normal completion and end of drain.
      if (pkt_end) begin
         word_cnt_d = '0;
         gnt_vld_d  = 1'b0;
         if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (reset) begin
         state_q      <= IDLE;
         gnt_vld_q    <= 1'b0;
         gnt_idx_q    <= 1'b0;
         last_grant_q <= 1'b1;
         word_cnt_q   <= '0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         gnt_vld_q    <= gnt_vld_d;
         gnt_idx_q    <= gnt_idx_d;
         last_grant_q <= last_grant_d;
         word_cnt_q   <= word_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign m.tvalid  = m_tvalid_o;
   assign m.tdata   = m_tdata_o;
   assign m.tkeep   = m_tkeep_o;
   assign m.tlast   = m_tlast_o;
   assign m.tuser   = m_tuser_o;
   assign s0.tready = sel_tready && gnt_vld_q && !gnt_idx_q;
   assign s1.tready = sel_tready && gnt_vld_q &&  gnt_idx_q;

`ifdef TX_ARB_STATS_EN
   logic pkt_done;
   assign pkt_done = xfer_acc && (sel_tlast || trunc_beat);

   tx_arb_stats u_stats (
      .user_clk  (user_clk),
      .reset     (reset),
      .pkt_done0 (pkt_done && !gnt_idx_q),
      .pkt_done1 (pkt_done &&  gnt_idx_q),
      .trunc_evt (xfer_acc && trunc_beat),
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1),
      .trunc_cnt (trunc_cnt)
   );
`else
   assign pkt_cnt0  = '0;
   assign pkt_cnt1  = '0;
   assign trunc_cnt = '0;
`endif
endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Scoreboard bench for tx_pkt_arbiter: directed packets, expected beats queued, monitor compares.
module tb_tx_pkt_arbiter;
   localparam int GAP_C = 2;
   localparam int MAX_W = 8;

   logic user_clk = 1'b0;
   logic reset    = 1'b1;
   always #5 user_clk = ~user_clk;

   tx_pkt_arbiter_if s0_if();
   tx_pkt_arbiter_if s1_if();
   tx_pkt_arbiter_if m_if();
   logic [31:0] pkt_cnt0, pkt_cnt1;
   logic [15:0] trunc_cnt;

   tx_pkt_arbiter #(.GAP_CYCLES(GAP_C), .MAX_WORDS(MAX_W)) dut (
      .user_clk  (user_clk),
      .reset     (reset),
      .s0        (s0_if),
      .s1        (s1_if),
      .m         (m_if),
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1),
      .trunc_cnt (trunc_cnt)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int failures = 0;
   int last_stall = 0;
   int c4_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [63:0] mk_data(input int port, input int id, input int beat);
      return {8'hA0 | 8'(port), 24'h0, 8'(id), 16'h0, 8'(beat)};
   endfunction

   // Expected output for a packet, including truncation at MAX_W beats.
   task automatic push_pkt(input int port, input int id, input int n);
      beat_t b;
      for (int i = 0; i < n && i < MAX_W; i++) begin
         b.data = mk_data(port, id, i);
         b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
         b.last = (i == n - 1) || (i == MAX_W - 1);
         b.user = (i == MAX_W - 1) && (i != n - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic set_src(input int port, input logic v, input logic [63:0] d,
                          input logic [7:0] k, input logic l);
      if (port == 0) begin
         s0_if.tvalid = v; s0_if.tdata = d; s0_if.tkeep = k; s0_if.tlast = l;
      end else begin
         s1_if.tvalid = v; s1_if.tdata = d; s1_if.tkeep = k; s1_if.tlast = l;
      end
   endtask

   function automatic logic get_ready(input int port);
      return (port == 0) ? s0_if.tready : s1_if.tready;
   endfunction

   task automatic send_pkt(input int port, input int id, input int n);
      int w;
      for (int i = 0; i < n; i++) begin
         set_src(port, 1'b1, mk_data(port, id, i), (i == n - 1) ? 8'h0F : 8'hFF, i == n - 1);
         w = 0;
         forever begin
            @(negedge user_clk);
            if (get_ready(port)) break;
            w++;
            if (w > 200) begin
               checks++; failures++;
               $display("FAIL send_timeout port=%0d id=%0d beat=%0d: got tready=0 expected tready=1", port, id, i);
               break;
            end
         end
         if (i == 0) last_stall = w;
         @(posedge user_clk); #1;
      end
      set_src(port, 1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: pops one expected beat per accepted output beat, and checks idle/ready rules.
   int idle_cnt = 0;
   bit in_pkt = 1'b0;
   bit fresh  = 1'b1;
   always @(negedge user_clk) begin
      beat_t e;
      if (reset) begin
         idle_cnt = 0; in_pkt = 1'b0; fresh = 1'b1;
      end else if (m_if.tvalid) begin
         if (m_if.tdata[63:56] == 8'hA0) begin
            chk("s0_tready_mirror", s0_if.tready, m_if.tready);
            chk("s1_tready_off", s1_if.tready, 0);
         end else begin
            chk("s1_tready_mirror", s1_if.tready, m_if.tready);
            chk("s0_tready_off", s0_if.tready, 0);
         end
         if (m_if.tready) begin
            if (!in_pkt && !fresh) chk("gap_ge_min", idle_cnt >= GAP_C, 1);
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat: got data %0h expected no beat", m_if.tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", m_if.tdata, e.data);
               chk("beat_keep", m_if.tkeep, e.keep);
               chk("beat_last", m_if.tlast, e.last);
               chk("beat_user", m_if.tuser, e.user);
            end
            in_pkt = !m_if.tlast;
            if (m_if.tlast) begin idle_cnt = 0; fresh = 1'b0; end
         end
      end else begin
         idle_cnt++;
         chk("idle_tdata_zero", m_if.tdata, 0);
         chk("idle_tkeep_zero", m_if.tkeep, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      beat_t b;
      logic [31:0] e_p0, e_p1;
      logic [15:0] e_tr;
      m_if.tready = 1'b1;
      s0_if.tuser = 1'b0;
      s1_if.tuser = 1'b0;
      set_src(0, 1'b1, 64'h1, 8'hFF, 1'b0);
      set_src(1, 1'b1, 64'h2, 8'hFF, 1'b0);
      reset = 1'b1;
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_m_tlast", m_if.tlast, 0);
      chk("rst_m_tuser", m_if.tuser, 0);
      chk("rst_s0_tready", s0_if.tready, 0);
      chk("rst_s1_tready", s1_if.tready, 0);
      chk("rst_pkt_cnt0", pkt_cnt0, 0);
      chk("rst_pkt_cnt1", pkt_cnt1, 0);
      chk("rst_trunc_cnt", trunc_cnt, 0);
      set_src(0, 1'b0, '0, '0, 1'b0);
      set_src(1, 1'b0, '0, '0, 1'b0);
      @(posedge user_clk); #1 reset = 1'b0;

      // Case 1: single s0 packet of 4 beats
      push_pkt(0, 1, 4);
      send_pkt(0, 1, 4);
      chk("c1_arb_latency", last_stall, 1);
      @(negedge user_clk); chk("c1_gap1_tvalid", m_if.tvalid, 0);
      @(negedge user_clk); chk("c1_gap2_tvalid", m_if.tvalid, 0);
      repeat (4) @(posedge user_clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge user_clk);
      #1 reset = 1'b0;

      // Case 2: both ports continuously busy, alternation expected
      push_pkt(0, 2, 3);
      push_pkt(1, 3, 3);
      push_pkt(0, 4, 3);
      push_pkt(1, 5, 3);
      fork
         begin send_pkt(0, 2, 3); send_pkt(0, 4, 3); end
         begin send_pkt(1, 3, 3); send_pkt(1, 5, 3); end
      join
      chk("c2_all_out", exp_q.size(), 0);
      repeat (4) @(posedge user_clk); #1;

      // Case 3: s1 sends 12 beats, truncated at 8
      push_pkt(1, 6, 12);
      send_pkt(1, 6, 12);
      chk("c3_all_out", exp_q.size(), 0);
      repeat (2) @(posedge user_clk); #1;
`ifdef TX_ARB_STATS_EN
      e_p0 = 32'd2; e_p1 = 32'd3; e_tr = 16'd1;
`else
      e_p0 = 32'd0; e_p1 = 32'd0; e_tr = 16'd0;
`endif
      chk("c3_trunc_cnt", trunc_cnt, e_tr);
      chk("c3_pkt_cnt0", pkt_cnt0, e_p0);
      chk("c3_pkt_cnt1", pkt_cnt1, e_p1);
      repeat (4) @(posedge user_clk); #1;

      // Case 4: m_tready toggling through a 5-beat packet
      push_pkt(0, 7, 5);
      fork
         send_pkt(0, 7, 5);
         begin
            repeat (11) begin @(posedge user_clk); #1 m_if.tready = ~m_if.tready; end
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
               @(negedge user_clk);
               if (m_if.tvalid) seen = 1'b1;
               if (seen) c4_cycles++;
               if (m_if.tvalid && m_if.tready && m_if.tlast) break;
            end
         end
      join
      m_if.tready = 1'b1;
      chk("c4_cycles", c4_cycles, 10);
      chk("c4_all_out", exp_q.size(), 0);
      repeat (4) @(posedge user_clk); #1;

      // Case 5: reset while beat 2 of an s0 packet is on the bus
      b.data = mk_data(0, 8, 0); b.keep = 8'hFF; b.last = 1'b0; b.user = 1'b0;
      exp_q.push_back(b);
      set_src(0, 1'b1, mk_data(0, 8, 0), 8'hFF, 1'b0);
      w = 0;
      forever begin
         @(negedge user_clk);
         if (s0_if.tready) break;
         w++;
         if (w > 50) begin
            checks++; failures++;
            $display("FAIL c5_beat1_timeout: got tready=0 expected tready=1");
            break;
         end
      end
      @(posedge user_clk); #1;
      set_src(0, 1'b1, mk_data(0, 8, 1), 8'hFF, 1'b0);
      m_if.tready = 1'b0;
      @(negedge user_clk);
      chk("c5_beat2_on_bus", m_if.tvalid, 1);
      @(posedge user_clk); #1 reset = 1'b1;
      @(negedge user_clk);
      chk("c5_rst_m_tvalid", m_if.tvalid, 0);
      chk("c5_rst_m_tlast", m_if.tlast, 0);
      chk("c5_rst_s0_tready", s0_if.tready, 0);
      chk("c5_rst_s1_tready", s1_if.tready, 0);
      m_if.tready = 1'b1;
      push_pkt(0, 9, 2);
      push_pkt(1, 10, 2);
      fork
         send_pkt(0, 9, 2);
         send_pkt(1, 10, 2);
         begin
            @(negedge user_clk);
            chk("c5_next_m_tvalid", m_if.tvalid, 0);
            chk("c5_next_s0_tready", s0_if.tready, 0);
            chk("c5_next_s1_tready", s1_if.tready, 0);
            @(posedge user_clk); #1 reset = 1'b0;
         end
      join
      chk("c5_all_out", exp_q.size(), 0);
      repeat (2) @(posedge user_clk); #1;
`ifdef TX_ARB_STATS_EN
      e_p0 = 32'd1; e_p1 = 32'd1; e_tr = 16'd0;
`else
      e_p0 = 32'd0; e_p1 = 32'd0; e_tr = 16'd0;
`endif
      chk("c5_pkt_cnt0", pkt_cnt0, e_p0);
      chk("c5_pkt_cnt1", pkt_cnt1, e_p1);
      chk("c5_trunc_cnt", trunc_cnt, e_tr);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/tx_pkt_arbiter.md
TX_PKT_ARBITER -- requirements
Module: tx_pkt_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2, giving the minimum idle cycles on the master port between packets (0 allowed).
REQ-002 SHALL have parameter MAX_WORDS, default 1024, giving the largest packet length in 64-bit beats before truncation (legal range 2..65535).
REQ-003 SHALL have port user_clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports s0_tdata/s1_tdata, input, 64 bits: requester payload.
REQ-006 SHALL have ports s0_tkeep/s1_tkeep, input, 8 bits: requester byte enables.
REQ-007 SHALL have ports s0_tvalid/s1_tvalid and s0_tlast/s1_tlast, input, 1 bit each: requester valid and end-of-packet.
REQ-008 SHALL have ports s0_tready/s1_tready, output, 1 bit each: requester accept.
REQ-009 SHALL have ports m_tdata (64), m_tkeep (8), m_tvalid (1), m_tlast (1) and m_tuser (1), all outputs: the stream toward the MAC TX interface. m_tuser=1 marks a truncated packet.
REQ-010 SHALL have port m_tready, input, 1 bit: downstream accept.
REQ-011 SHALL have ports pkt_cnt0 and pkt_cnt1, output, 32 bits each, and trunc_cnt, output, 16 bits: statistics (see Configuration).

Function
REQ-012 SHALL arbitrate at packet granularity; once granted, a port owns the master until its tlast beat is accepted or the packet is truncated.
REQ-013 SHALL implement states IDLE, XFER, DRAIN and GAP.
REQ-014 IDLE: if any sX_tvalid=1, SHALL register the grant and go to XFER on the next cycle. This is one cycle of arbitration latency; no beat is transferred in IDLE.
REQ-015 Round-robin: if both ports are valid in IDLE, SHALL grant the port not in last_grant; if one port is valid, SHALL grant it. last_grant updates on every grant.
REQ-016 XFER: m_tdata, m_tkeep, m_tvalid and m_tlast SHALL equal the granted port's signals; the granted sX_tready SHALL equal m_tready; the non-granted sX_tready SHALL be 0.
REQ-017 A beat is accepted when m_tvalid & m_tready. A 16-bit word counter SHALL increment per accepted beat and clear on leaving XFER.
REQ-018 On an accepted beat with tlast=1: SHALL go to GAP if GAP_CYCLES>0, else to IDLE.
REQ-019 If the counter equals MAX_WORDS-1 and the current beat has tlast=0, SHALL drive m_tlast=1 and m_tuser=1 on that beat. On its acceptance SHALL go to DRAIN.
REQ-020 m_tuser SHALL be 0 on every other beat.
REQ-021 DRAIN: m_tvalid=0; the granted sX_tready=1; input beats are discarded; on an accepted input beat with tlast=1, SHALL go to GAP (or to IDLE when GAP_CYCLES=0).
REQ-022 GAP: m_tvalid=0; both sX_tready=0; a down-counter loaded with GAP_CYCLES-1 SHALL return to IDLE on the cycle it reads 0.
REQ-023 In IDLE and GAP, m_tvalid=0 and both sX_tready=0; m_tdata and m_tkeep SHALL read 0 when m_tvalid=0.
REQ-024 A single-beat packet (tlast on the first beat) SHALL complete normally with no truncation.
REQ-025 A tvalid drop mid-packet SHALL hold the grant; the other port SHALL NOT be serviced.

Reset
REQ-026 During reset SHALL hold the state at IDLE, the grant at none, and last_grant=1 (port 0 wins the first tie), and SHALL clear the word and gap counters.
REQ-027 Reset SHALL force m_tvalid, m_tlast, m_tuser, s0_tready and s1_tready to 0 in the same cycle.
REQ-028 Reset SHALL clear the statistics counters.
REQ-029 Reset mid-packet SHALL abandon the packet without emitting tlast; the first transfer after reset SHALL be a fresh arbitration.

Configuration
REQ-030 With macro TX_ARB_STATS_EN defined: pkt_cnt0/pkt_cnt1 SHALL increment per packet completed (tlast accepted or truncated) from that port, and trunc_cnt SHALL increment per truncation. All three SHALL wrap at full scale.
REQ-031 Without TX_ARB_STATS_EN: the three outputs SHALL remain present, tied to 0, with no counter flops.

Structure
REQ-032 Package tx_arb_pkg SHALL hold the state enum (IDLE, XFER, DRAIN, GAP), NUM_PORTS=2 and the counter width constants.
REQ-033 Sub-module tx_arb_stats SHALL hold the statistics counters and SHALL be instantiated only under TX_ARB_STATS_EN.

Verification
REQ-034 Case 1: s0 sends 4 beats, s1 idle, m_tready=1 -> first m_tvalid appears 1 cycle after s0_tvalid; 4 beats out; m_tlast on beat 4; then 2 idle cycles.
REQ-035 Case 2: both ports hold a 3-beat packet continuously after reset -> output order s0, s1, s0, s1, with ≥2 idle cycles between packets.
REQ-036 Case 3: MAX_WORDS=8, s1 sends 12 beats -> 8 beats out, beat 8 has m_tlast=1 and m_tuser=1; beats 9-12 are accepted and discarded; trunc_cnt=1.
REQ-037 Case 4: m_tready toggles 1/0 every cycle during a 5-beat s0 packet -> data is identical and in order, s0_tready mirrors m_tready, and the packet completes in 10 cycles.
REQ-038 Case 5: reset asserted on beat 2 of s0's packet -> the next cycle has m_tvalid=0 and both tready=0; after release s1 is pending and s0 is re-valid, so s0 is granted (last_grant=1).
